pipelined_alu: RTL and testbench
================================

PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (WIDTH >= 2).
REQ-002 SHALL have ports:
  - i_clk  input  1  sole clock; all state updates on rising edge.
  - i_rst_n  input  1  reset; asynchronous assert, active-low.
  - i_valid  input  1  upstream operation valid.
  - o_ready  output  1  block can accept an operation this cycle.
  - i_zx, i_nx, i_zy, i_ny, i_f, i_no  input  1 each  Hack-style control bits.
  - i_acc  input  1  replace X operand with accumulator value.
  - i_X, i_Y  input  WIDTH  operands.
  - o_valid  output  1  result valid.
  - i_ready  input  1  downstream accepts result.
  - o_O  output  WIDTH  result.
  - o_zr, o_ng, o_co  output  1 each  zero, negative, carry flags.
REQ-003 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-004 SHALL have two register stages, S1 (operands, controls) and S2 (result, flags), each with its own valid bit.
REQ-005 Input transfer SHALL occur when i_valid && o_ready; output transfer SHALL occur when o_valid && i_ready.
REQ-006 S1 SHALL register x' and y' and the i_f, i_no controls on input transfer:
  - x' = (zx ? 0 : X), then inverted if nx.
  - y' likewise from i_zy, i_ny.
  - X = accumulator when i_acc=1, else i_X.
REQ-007 S2 SHALL register r and flags when S1 advances:
  - r = f ? x'+y' (mod 2^WIDTH) : x'&y', then inverted if no.
REQ-008 o_zr SHALL be 1 iff r==0; o_ng SHALL equal r[WIDTH-1].
REQ-009 o_co SHALL be the carry-out of x'+y' when f=1, independent of no; 0 when f=0.
REQ-010 S1 SHALL advance into S2 when S1 is valid and (S2 is empty or S2 performs an output transfer this cycle).
REQ-011 o_ready SHALL be combinational: !S1valid || S1 advances this cycle.
  - Full throughput is one op/cycle.
  - Latency is exactly 2 cycles from input transfer to o_valid when i_ready stays 1.
REQ-012 With i_ready=0, the pipeline SHALL hold up to 2 ops.
  - o_valid, o_O and flags SHALL remain stable until transfer.
  - Ordering SHALL be FIFO; no op is dropped or duplicated.
REQ-013 Accumulator SHALL load o_O on every output transfer.
REQ-014 An i_acc op SHALL sample the accumulator value at its input transfer; in-flight results are not forwarded.
REQ-015 Simultaneous input and output transfer in the same cycle SHALL both complete.

Reset
REQ-016 While i_rst_n=0, the following SHALL be 0: S1/S2 valid, o_valid, o_O, o_zr, o_ng, o_co, accumulator, all stage registers.
REQ-017 o_ready SHALL be 1 from the first cycle after reset release.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight ops; no o_valid SHALL appear for them after release.

Verification (WIDTH=8)
REQ-019 Scenario: X=5, Y=3, controls 000010 (zx nx zy ny f no), i_ready=1 -> two cycles later o_valid=1, o_O=8, zr=0, ng=0, co=0.
REQ-020 Scenario: X=3, Y=5, controls 010011 (x-y) -> o_O=0xFE, ng=1, zr=0.
REQ-021 Scenario: X=0xFF, Y=0x01, add -> o_O=0x00, zr=1, co=1.
REQ-022 Scenario: 3 back-to-back ops with i_ready=0 -> 2 accepted, o_ready=0 on the 3rd; on i_ready=1, results emerge in order, then the 3rd is accepted.
REQ-023 Scenario: op1 X=1,Y=0 add; after its output transfer, 3 ops with i_acc=1, Y=1, add, each issued after the prior output transfer -> outputs 1,2,3,4.
REQ-024 Scenario: reset pulse with 2 ops in flight -> o_valid=0, o_O=0, accumulator=0 after release; next op X=2,Y=2 add -> o_O=4.

Source files
------------

// File: rtl/pipelined_alu.sv
// Two-stage Hack-style ALU with valid/ready handshaking on both sides.
// S1 holds preprocessed operands; S2 holds the result and flags.
module pipelined_alu #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_zx,
  input  logic             i_nx,
  input  logic             i_zy,
  input  logic             i_ny,
  input  logic             i_f,
  input  logic             i_no,
  input  logic             i_acc,
  input  logic [WIDTH-1:0] i_X,
  input  logic [WIDTH-1:0] i_Y,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_O,
  output logic             o_zr,
  output logic             o_ng,
  output logic             o_co
);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic             f_reg;
  logic             no_reg;
  logic [WIDTH-1:0] acc_reg;

  logic             in_xfer;
  logic             out_xfer;
  logic             s1_adv;
  logic [WIDTH-1:0] x_src;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_next;

  assign out_xfer = o_valid && i_ready;
  assign s1_adv   = s1_valid_reg && (!o_valid || out_xfer);
  assign o_ready  = !s1_valid_reg || s1_adv;
  assign in_xfer  = i_valid && o_ready;

  // Operand preprocessing happens before S1 so S2 only needs the adder/and.
  always_comb begin
    x_src  = i_acc ? acc_reg : i_X;
    x_next = i_zx ? '0 : x_src;
    if (i_nx) x_next = ~x_next;
    y_next = i_zy ? '0 : i_Y;
    if (i_ny) y_next = ~y_next;
  end

  always_comb begin
    sum    = {1'b0, x_reg} + {1'b0, y_reg};
    r_next = f_reg ? sum[WIDTH-1:0] : (x_reg & y_reg);
    if (no_reg) r_next = ~r_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_reg <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      f_reg        <= 1'b0;
      no_reg       <= 1'b0;
    end else begin
      s1_valid_reg <= in_xfer || (s1_valid_reg && !s1_adv);
      if (in_xfer) begin
        x_reg  <= x_next;
        y_reg  <= y_next;
        f_reg  <= i_f;
        no_reg <= i_no;
      end
    end
  end

  // Carry is taken from the raw sum, so output inversion does not affect it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_O     <= '0;
      o_zr    <= 1'b0;
      o_ng    <= 1'b0;
      o_co    <= 1'b0;
    end else begin
      o_valid <= s1_adv || (o_valid && !out_xfer);
      if (s1_adv) begin
        o_O  <= r_next;
        o_zr <= (r_next == '0);
        o_ng <= r_next[WIDTH-1];
        o_co <= f_reg && sum[WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_reg <= '0;
    end else if (out_xfer) begin
      acc_reg <= o_O;
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Scoreboard bench for pipelined_alu: driver pushes expected results at input
// transfer, a negedge monitor compares and pops at output transfer.
module tb_pipelined_alu;

  typedef struct packed {
    logic [7:0] o;
    logic       zr;
    logic       ng;
    logic       co;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready_dut;
  logic       zx, nx, zy, ny, fn, no;
  logic       use_acc;
  logic [7:0] opx, opy;
  logic       out_valid;
  logic       ds_ready;
  logic [7:0] out_o;
  logic       out_zr, out_ng, out_co;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_acc;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready_dut),
    .i_zx    (zx),
    .i_nx    (nx),
    .i_zy    (zy),
    .i_ny    (ny),
    .i_f     (fn),
    .i_no    (no),
    .i_acc   (use_acc),
    .i_X     (opx),
    .i_Y     (opy),
    .o_valid (out_valid),
    .i_ready (ds_ready),
    .o_O     (out_o),
    .o_zr    (out_zr),
    .o_ng    (out_ng),
    .o_co    (out_co)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int o, input bit z, input bit n, input bit c);
    exp_t e;
    e.o  = o[7:0];
    e.zr = z;
    e.ng = n;
    e.co = c;
    return e;
  endfunction

  // Reference model in plain integer arithmetic; c = {zx,nx,zy,ny,f,no}.
  function automatic exp_t model(input logic [5:0] c, input int x, input int y);
    int xa, ya, s, r;
    exp_t e;
    xa = c[5] ? 0 : x;
    if (c[4]) xa = 255 - xa;
    ya = c[3] ? 0 : y;
    if (c[2]) ya = 255 - ya;
    s = xa + ya;
    r = c[1] ? (s % 256) : (xa & ya);
    if (c[0]) r = 255 - r;
    e.o  = r[7:0];
    e.zr = (r == 0);
    e.ng = (r >= 128);
    e.co = c[1] && (s > 255);
    return e;
  endfunction

  task automatic drive(input logic [5:0] c, input logic a, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    {zx, nx, zy, ny, fn, no} = c;
    use_acc = a;
    opx = x;
    opy = y;
  endtask

  // Holds the op until accepted; called just after a rising edge.
  task automatic issue(input logic [5:0] c, input logic a, input logic [7:0] x, input logic [7:0] y,
                       input bit use_exp, input exp_t e, input bit rnd_ready);
    exp_t m;
    drive(c, a, x, y);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_ready_dut) begin
        m = use_exp ? e : model(c, a ? int'(model_acc) : int'(x), int'(y));
        sb.push_back(m);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd_ready) ds_ready = 1'($urandom_range(0, 1));
    end
    check("issue_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_acc <= 8'h00;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb[0];
        check("o_O", out_o, mon_e.o);
        check("o_zr", out_zr, mon_e.zr);
        check("o_ng", out_ng, mon_e.ng);
        check("o_co", out_co, mon_e.co);
        if (ds_ready) begin
          void'(sb.pop_front());
          model_acc <= mon_e.o;
          $display("out o=%02h zr=%0d ng=%0d co=%0d", out_o, out_zr, out_ng, out_co);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ghosts;
    rst_n = 1'b0;
    in_valid = 1'b0;
    ds_ready = 1'b0;
    {zx, nx, zy, ny, fn, no} = 6'b0;
    use_acc = 1'b0;
    opx = 8'h00;
    opy = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_o_valid", out_valid, 0);
    check("rst_o_O", out_o, 0);
    check("rst_flags", {out_zr, out_ng, out_co}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", out_ready_dut, 1);
    @(posedge clk); #1;
    ds_ready = 1'b1;

    // Basic add with two-cycle latency.
    issue(6'b000010, 1'b0, 8'd5, 8'd3, 1'b1, mk(8, 0, 0, 0), 1'b0);
    @(negedge clk);
    check("latency_c1", out_valid, 0);
    @(negedge clk);
    check("latency_c2", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // x - y, and add wrapping to zero.
    issue(6'b010011, 1'b0, 8'd3, 8'd5, 1'b1, mk(8'hFE, 0, 1, 1), 1'b0);
    drain();
    issue(6'b000010, 1'b0, 8'hFF, 8'h01, 1'b1, mk(0, 1, 0, 1), 1'b0);
    drain();

    // Backpressure: two ops fill the pipe, the third must stall.
    ds_ready = 1'b0;
    issue(6'b000010, 1'b0, 8'd10, 8'd20, 1'b1, mk(30, 0, 0, 0), 1'b0);
    issue(6'b000000, 1'b0, 8'h0F, 8'h3C, 1'b1, mk(8'h0C, 0, 0, 0), 1'b0);
    drive(6'b000010, 1'b0, 8'd1, 8'd1);
    @(negedge clk);
    check("o_ready_full", out_ready_dut, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("o_ready_still_full", out_ready_dut, 0);
    @(posedge clk); #1;
    ds_ready = 1'b1;
    issue(6'b000010, 1'b0, 8'd1, 8'd1, 1'b1, mk(2, 0, 0, 0), 1'b0);
    drain();

    // Accumulator chain.
    issue(6'b000010, 1'b0, 8'd1, 8'd0, 1'b1, mk(1, 0, 0, 0), 1'b0);
    drain();
    for (int k = 2; k <= 4; k++) begin
      issue(6'b000010, 1'b1, 8'($urandom), 8'd1, 1'b1, mk(k, 0, 0, 0), 1'b0);
      drain();
    end

    // Reset with two ops in flight.
    ds_ready = 1'b0;
    issue(6'b000010, 1'b0, 8'd7, 8'd9, 1'b1, mk(16, 0, 0, 0), 1'b0);
    issue(6'b000010, 1'b0, 8'd11, 8'd13, 1'b1, mk(24, 0, 0, 0), 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_o_valid", out_valid, 0);
    check("midrst_o_O", out_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ds_ready = 1'b1;
    ghosts = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    check("ghost_valid", ghosts, 0);
    @(posedge clk); #1;
    issue(6'b000010, 1'b1, 8'h55, 8'd0, 1'b1, mk(0, 1, 0, 0), 1'b0);
    drain();
    issue(6'b000010, 1'b0, 8'd2, 8'd2, 1'b1, mk(4, 0, 0, 0), 1'b0);
    drain();

    // Randomized traffic with random backpressure.
    for (int t = 0; t < 300; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
        ds_ready = 1'($urandom_range(0, 1));
      end
      issue(6'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0, mk(0, 0, 0, 0), 1'b1);
    end
    ds_ready = 1'b1;
    drain();
    check("final_queue_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
